// File: rtl/rf_serial_ctrl_if.sv
// Pin bundle between the serial frontend pins and the 32 x 64 register-file array.
// The controller takes the slave side; the pin/array environment takes the master side.
interface rf_serial_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
);
    logic              cs_n;
    logic              sdi;
    logic              sdo;
    logic              busy;
    logic              err;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_we;
    logic              rf_re;
    logic [DATA_W-1:0] rf_rdata;

    modport master (
        output cs_n, sdi, rf_rdata,
        input  sdo, busy, err, rf_addr, rf_wdata, rf_we, rf_re
    );

    modport slave (
        input  cs_n, sdi, rf_rdata,
        output sdo, busy, err, rf_addr, rf_wdata, rf_we, rf_re
    );
endinterface

// File: rtl/rf_serial_ctrl.sv
// Bit-serial command sequencer: deframes cs_n-framed READ/WRITE bursts into register-file
// strobes and returns read data MSB-first on sdo.
//
// state  | meaning
// IDLE   | waiting for cs_n low (only after cs_n has been seen high since reset)
// OPCODE | k=0 sampled, k=1 completes the opcode
// ADDR   | shifting in the 5-bit start address
// WDATA  | shifting in write words, strobe rf_we per completed word
// RDATA  | strobing rf_re and shifting read words out on sdo
// DRAIN  | NOP or reserved opcode, ignore sdi until cs_n rises
module rf_serial_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    rf_serial_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_OPCODE = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_WDATA  = 3'd3;
    localparam logic [2:0] S_RDATA  = 3'd4;
    localparam logic [2:0] S_DRAIN  = 3'd5;

    logic [2:0]        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic              op_hi;
    logic              armed;
    logic              err_q;
    logic              sdo_q;
    logic              rf_we_q;
    logic              rf_re_q;
    logic [ADDR_W-1:0] addr_sr;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] rf_addr_q;
    logic [DATA_W-1:0] wsr;
    logic [DATA_W-1:0] rsr;
    logic [DATA_W-1:0] rf_wdata_q;
    logic [ADDR_W-1:0] addr_full;
    logic [DATA_W-1:0] word_full;

    assign addr_full = {addr_sr[ADDR_W-2:0], bus.sdi};
    assign word_full = {wsr[DATA_W-2:0], bus.sdi};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            op_hi      <= 1'b0;
            armed      <= 1'b0;
            err_q      <= 1'b0;
            sdo_q      <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_re_q    <= 1'b0;
            addr_sr    <= '0;
            next_addr  <= '0;
            rf_addr_q  <= '0;
            wsr        <= '0;
            rsr        <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= 1'b0;
            rf_re_q <= 1'b0;
            if (bus.cs_n) begin
                // Abort or frame end: partial words are dropped, read shifter flushed.
                state   <= S_IDLE;
                armed   <= 1'b1;
                bit_cnt <= '0;
                sdo_q   <= 1'b0;
                rsr     <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (armed) begin
                            op_hi <= bus.sdi;
                            state <= S_OPCODE;
                        end
                    end
                    S_OPCODE: begin
                        case ({op_hi, bus.sdi})
                            2'b01, 2'b10: begin
                                state   <= S_ADDR;
                                bit_cnt <= CNT_W'(ADDR_W - 1);
                            end
                            2'b11: begin
                                err_q <= 1'b1;
                                state <= S_DRAIN;
                            end
                            default: state <= S_DRAIN;
                        endcase
                    end
                    S_ADDR: begin
                        addr_sr <= addr_full;
                        if (bit_cnt == '0) begin
                            bit_cnt <= CNT_W'(DATA_W - 1);
                            if (op_hi) begin
                                state     <= S_WDATA;
                                next_addr <= addr_full;
                            end else begin
                                state     <= S_RDATA;
                                rf_re_q   <= 1'b1;
                                rf_addr_q <= addr_full;
                                next_addr <= addr_full + 1'b1;
                                rsr       <= '0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                    S_WDATA: begin
                        wsr <= word_full;
                        if (bit_cnt == '0) begin
                            rf_we_q    <= 1'b1;
                            rf_wdata_q <= word_full;
                            rf_addr_q  <= next_addr;
                            next_addr  <= next_addr + 1'b1;
                            bit_cnt    <= CNT_W'(DATA_W - 1);
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                    S_RDATA: begin
                        // Data is valid the cycle after the strobe; capture one count later.
                        if (bit_cnt == CNT_W'(DATA_W - 2)) begin
                            sdo_q <= bus.rf_rdata[DATA_W-1];
                            rsr   <= {bus.rf_rdata[DATA_W-2:0], 1'b0};
                        end else begin
                            sdo_q <= rsr[DATA_W-1];
                            rsr   <= {rsr[DATA_W-2:0], 1'b0};
                        end
                        if (bit_cnt == '0) begin
                            rf_re_q   <= 1'b1;
                            rf_addr_q <= next_addr;
                            next_addr <= next_addr + 1'b1;
                            bit_cnt   <= CNT_W'(DATA_W - 1);
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                    S_DRAIN: ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.busy     = (state != S_IDLE);
    assign bus.err      = err_q;
    assign bus.sdo      = sdo_q;
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_re    = rf_re_q;
    assign bus.rf_addr  = rf_addr_q;
    assign bus.rf_wdata = rf_wdata_q;
endmodule

// File: tb/tb_rf_serial_ctrl.sv
// Bench for rf_serial_ctrl: frame-level reference model feeds an expectation queue that a
// separate monitor drains one cycle at a time, with a register-file array model on the rf pins.
module tb_rf_serial_ctrl;
    logic clk;
    logic rst_n;

    rf_serial_ctrl_if #(.ADDR_W(5), .DATA_W(64)) bus ();

    rf_serial_ctrl #(.ADDR_W(5), .DATA_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic        sdo;
        logic        busy;
        logic        err;
        logic        chk_addr;
        logic [4:0]  addr;
        logic        chk_wd;
        logic [63:0] wdata;
    } exp_t;

    exp_t        expq[$];
    exp_t        mon_e;
    int          compared   = 0;
    int          mismatched = 0;

    logic [63:0] dev_mem [32];
    logic [63:0] ref_mem [32];
    logic [63:0] fw[$];

    int          k_m;
    bit          armed_m;
    bit          err_m;
    logic [1:0]  op_m;
    logic [4:0]  a_m;
    logic [63:0] wacc;

    // Register-file array: data only valid the cycle after rf_re, junk otherwise.
    always @(posedge clk) begin
        if (bus.rf_we) dev_mem[bus.rf_addr] <= bus.rf_wdata;
        if (bus.rf_re) bus.rf_rdata <= dev_mem[bus.rf_addr];
        else           bus.rf_rdata <= {$urandom, $urandom};
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        compared++;
        if (act !== exp_v) begin
            mismatched++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp_v);
        end
    endfunction

    always begin
        @(posedge clk);
        #2;
        if (expq.size() != 0) begin
            mon_e = expq.pop_front();
            chk("rf_we", 64'(bus.rf_we), 64'(mon_e.we));
            chk("rf_re", 64'(bus.rf_re), 64'(mon_e.re));
            chk("sdo",   64'(bus.sdo),   64'(mon_e.sdo));
            chk("busy",  64'(bus.busy),  64'(mon_e.busy));
            chk("err",   64'(bus.err),   64'(mon_e.err));
            if (mon_e.chk_addr) chk("rf_addr", 64'(bus.rf_addr), 64'(mon_e.addr));
            if (mon_e.chk_wd)   chk("rf_wdata", bus.rf_wdata, mon_e.wdata);
        end
    end

    // One input sample plus the outputs the frame rules predict right after that edge.
    task automatic step(input logic cs_v, input logic sdi_v, input logic rst_v);
        exp_t e;
        int   n;
        int   j;
        @(negedge clk);
        bus.cs_n = cs_v;
        bus.sdi  = sdi_v;
        rst_n    = rst_v;
        e = '{we: 1'b0, re: 1'b0, sdo: 1'b0, busy: 1'b0, err: 1'b0,
              chk_addr: 1'b0, addr: 5'd0, chk_wd: 1'b0, wdata: 64'd0};
        if (!rst_v) begin
            k_m = -1; armed_m = 0; err_m = 0;
            e.chk_addr = 1'b1;
            e.chk_wd   = 1'b1;
        end else if (cs_v) begin
            k_m = -1; armed_m = 1;
        end else if (k_m >= 0 || armed_m) begin
            k_m = k_m + 1;
            e.busy = 1'b1;
            if (k_m <= 1) op_m = {op_m[0], sdi_v};
            if (k_m == 1 && op_m == 2'b11) err_m = 1;
            if (k_m >= 2 && k_m <= 6) a_m = {a_m[3:0], sdi_v};
            if (op_m == 2'b10 && k_m >= 7) begin
                wacc = {wacc[62:0], sdi_v};
                if ((k_m - 7) % 64 == 63) begin
                    n = (k_m - 70) / 64;
                    e.we = 1'b1;
                    e.chk_addr = 1'b1;
                    e.addr = 5'(int'(a_m) + n);
                    e.chk_wd = 1'b1;
                    e.wdata = wacc;
                    ref_mem[e.addr] = wacc;
                end
            end
            if (op_m == 2'b01 && k_m >= 6 && (k_m - 6) % 64 == 0) begin
                e.re = 1'b1;
                e.chk_addr = 1'b1;
                e.addr = 5'(int'(a_m) + (k_m - 6) / 64);
            end
            if (op_m == 2'b01 && k_m + 1 >= 9) begin
                j = k_m + 1 - 9;
                e.sdo = ref_mem[5'(int'(a_m) + j / 64)][63 - (j % 64)];
            end
        end
        e.err = err_m;
        expq.push_back(e);
    endtask

    task automatic frame(input logic [1:0] op, input logic [4:0] a, input int len, input int gap);
        logic       b;
        int         n;
        logic [63:0] w;
        for (int k = 0; k < len; k++) begin
            if (k < 2)      b = op[1 - k];
            else if (k < 7) b = a[6 - k];
            else begin
                n = (k - 7) / 64;
                if (op == 2'b10 && n < fw.size()) begin
                    w = fw[n];
                    b = w[63 - ((k - 7) % 64)];
                end else begin
                    b = 1'($urandom_range(0, 1));
                end
            end
            step(1'b0, b, 1'b1);
        end
        for (int g = 0; g < gap; g++) step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
    endtask

    task automatic rand_words(input int cnt);
        fw.delete();
        for (int i = 0; i < cnt; i++) fw.push_back({$urandom, $urandom});
    endtask

    initial begin
        logic [1:0] op;
        rst_n    = 1'b0;
        bus.cs_n = 1'b0;
        bus.sdi  = 1'b0;
        k_m = -1; armed_m = 0; err_m = 0; op_m = 2'b00; a_m = 5'd0; wacc = 64'd0;

        // Reset held with cs_n low and sdi toggling; the frame must not resume afterwards.
        for (int i = 0; i < 3; i++) step(1'b0, 1'(i % 2), 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);

        rand_words(32);
        frame(2'b10, 5'($urandom_range(0, 31)), 7 + 64 * 32, 2);

        fw.delete(); fw.push_back(64'hDEADBEEF_01234567);
        frame(2'b10, 5'd3, 71, 1);
        frame(2'b01, 5'd3, 73, 2);

        fw.delete(); fw.push_back(64'h1); fw.push_back(64'h2);
        frame(2'b10, 5'd31, 135, 1);
        frame(2'b01, 5'd31, 137, 2);

        // Abort after 40 data bits, then an immediate read frame.
        rand_words(1);
        frame(2'b10, 5'd5, 47, 1);
        frame(2'b01, 5'd5, 73, 1);
        frame(2'b01, 5'd7, 40, 1);

        frame(2'b11, 5'd0, 102, 2);
        rand_words(1);
        frame(2'b10, 5'd12, 71, 2);
        frame(2'b01, 5'd12, 73, 1);
        frame(2'b00, 5'd0, 20, 1);

        for (int f = 0; f < 14; f++) begin
            case ($urandom_range(0, 2))
                0:       op = 2'b00;
                1:       op = 2'b01;
                default: op = 2'b10;
            endcase
            rand_words(3);
            frame(op, 5'($urandom_range(0, 31)), $urandom_range(1, 210), $urandom_range(1, 3));
        end

        // Reset on the edge that would strobe a write; err must clear.
        rand_words(1);
        frame(2'b10, 5'd9, 70, 0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        frame(2'b01, 5'd9, 73, 2);
        rand_words(1);
        frame(2'b10, 5'd9, 71, 2);

        repeat (4) @(negedge clk);
        chk("expect_queue_drained", 64'(expq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/rf_serial_ctrl.md
# rf_serial_ctrl

Bit-serial command sequencer for the 32 x 64 register file. It deframes a chip-select-framed serial stream into read, write and burst commands, and drives the register file's address, write-data and strobe pins. Read data is returned MSB-first on a serial output. It sits between the top-level pins and the register-file array, and replaces direct pin control of shift, read and write.

## Interface
Parameters:
- ADDR_W, default 5: register-file address width; burst addresses wrap mod 2^ADDR_W.
- DATA_W, default 64: register-file word width; one serial word = DATA_W bits.

Ports:
- clk, input, 1: clock; all logic on posedge.
- rst_n, input, 1: reset, synchronous, active-low.
- cs_n, input, 1: frame select, active-low; a frame is a contiguous run of cycles with cs_n sampled low.
- sdi, input, 1: serial command/data in, sampled on posedge while cs_n low.
- sdo, output, 1: serial read data out, registered.
- busy, output, 1: high whenever the FSM is not IDLE.
- err, output, 1: sticky; set by a reserved opcode, cleared only by reset.
- rf_addr, output, ADDR_W: register-file address, registered.
- rf_wdata, output, DATA_W: register-file write data, registered.
- rf_we, output, 1: one-cycle write strobe.
- rf_re, output, 1: one-cycle read strobe.
- rf_rdata, input, DATA_W: read data, valid exactly one cycle after rf_re.

## Operation
- Frame cycle index k counts from 0, starting at the first posedge where cs_n is sampled low.
- Opcode field:
  - k=0..1 carry the opcode, MSB first.
  - 01 = READ, 10 = WRITE, 00 = NOP, 11 = reserved.
- Address field: k=2..6 carry address A, MSB first.
- FSM states: IDLE, OPCODE, ADDR, WDATA, RDATA, DRAIN.
  - DRAIN ignores sdi until cs_n is high.
  - NOP goes to DRAIN after the opcode field.
  - Reserved opcode sets err and goes to DRAIN. No strobes are issued.
- WRITE:
  - Word n occupies k = 7+64n .. 70+64n, MSB first.
  - After the last bit of word n is sampled, the next cycle has rf_we=1, rf_addr=A+n (mod 32), and rf_wdata = that word.
  - The burst continues for as long as cs_n stays low.
- READ:
  - Word n: rf_re=1 with rf_addr=A+n (mod 32) during k=7+64n.
  - rf_rdata is captured at the end of k=8+64n.
  - sdo carries bit 63..0 during k=9+64n .. 72+64n.
  - Bursts are seamless: the next word's strobe is in k=71+64n, and its capture coincides with the last bit of the previous word.
  - sdi is ignored in RDATA.
  - sdo=0 at all other times.
- Abort:
  - cs_n sampled high in any state returns the FSM to IDLE at that edge.
  - A partially received write word is discarded, with no rf_we.
  - The read shift register clears, so sdo=0 the next cycle.
  - A strobe already registered before cs_n rose still completes its single cycle.
- Simultaneous events: rst_n low dominates cs_n and sdi. rf_we and rf_re are never high in the same cycle.
- Frames need at least 1 cycle of cs_n high between them. A new frame starting the cycle after an abort is parsed normally.

## Timing
- Reset values: sdo=0, busy=0, err=0, rf_addr=0, rf_wdata=0, rf_we=0, rf_re=0; FSM in IDLE; bit counters 0.
- Write latency: the rf_we cycle immediately follows the edge that samples data bit 0.
- Read latency: the first sdo bit appears 2 cycles after the rf_re cycle.
- busy rises in the cycle after k=0 is sampled. It falls in the cycle after cs_n is sampled high.
- rf_addr holds its last value between strobes. rf_wdata holds its value until the next completed word.
- Reset mid-frame:
  - The FSM returns to IDLE.
  - Outputs take reset values at the next edge. Any pending strobe is cancelled.
  - The frame is not resumed. A new cs_n low run is needed, and cs_n must be high for at least 1 cycle first.

## Test plan
- Reset: hold rst_n low 3 cycles with cs_n=0 and sdi toggling -> all outputs 0, busy=0, no strobes.
- Single write: opcode 10, A=3, data 64'hDEADBEEF_01234567 -> exactly one rf_we pulse, in the cycle after k=70, with rf_addr=3 and rf_wdata=64'hDEADBEEF_01234567.
- Single read: opcode 01, A=3, memory model returns 64'hDEADBEEF_01234567 -> rf_re at k=7 with rf_addr=3; sdo during k=9..72 equals the word MSB first; sdo=0 at k=7..8.
- Burst with wrap: WRITE at A=31 with two words 64'h1 and 64'h2 -> rf_we with (31, 64'h1) then (0, 64'h2). A READ burst at A=31 returns both words back-to-back on sdo with no gap cycle.
- Abort: WRITE A=5 and raise cs_n after 40 data bits -> no rf_we, busy falls next cycle; an immediate READ A=5 frame issues rf_re with rf_addr=5.
- Reserved opcode: opcode 11 followed by 100 bits -> err=1, no strobes; err stays 1 through a following valid WRITE frame, which still executes; err clears only on rst_n.
